// File: rtl/mr_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : mr_pkg                                                   |
// | Shared defaults and constants for the general-purpose reg bank.    |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
package mr_pkg;

   // Default data width and register count of the machine register file
   localparam int DEF_N     = 16;
   localparam int DEF_DEPTH = 8;

   // Index of the architectural zero register
   localparam int REG_ZERO  = 0;

endpackage : mr_pkg
`default_nettype wire

// File: rtl/reg_ar.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : reg_ar                                                   |
// | N-bit register: async active-low reset, sync clear, load enable.   |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module reg_ar #(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         ld,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   // Storage: reset wins, then clear, then load; otherwise hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (ld) begin
         q <= d;
      end
   end

endmodule : reg_ar
`default_nettype wire

// File: rtl/reg_bank.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : reg_bank                                                 |
// | General-purpose register file: one sync write port, two comb read  |
// | ports, optional hard-wired R0 and optional write-to-read bypass.   |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module reg_bank
   import mr_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int AW       = $clog2(DEPTH),
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ld,
   input  logic          clr,
   input  logic [AW-1:0] wr_addr,
   input  logic [N-1:0]  in,
   input  logic [AW-1:0] rd_addr_a,
   output logic [N-1:0]  out_a,
   input  logic [AW-1:0] rd_addr_b,
   output logic [N-1:0]  out_b
);

   // Per-register stored value (constant zero for a hard-wired R0)
   logic [N-1:0]     regs [DEPTH];
   // One-hot: wr_addr selects this register and it is writable.
   // Out-of-range addresses match no entry, so such writes vanish.
   logic [DEPTH-1:0] addr_hit;
   logic             bypass_ok;

   genvar i;
   generate
      for (i = 0; i < DEPTH; i++) begin : g_reg
         if ((ZERO_REG != 0) && (i == REG_ZERO)) begin : g_zero
            assign addr_hit[i] = 1'b0;
            assign regs[i]     = '0;
         end else begin : g_store
            assign addr_hit[i] = (wr_addr == AW'(i));
            reg_ar #(
               .N (N)
            ) u_reg (
               .clk   (clk),
               .rst_n (rst_n),
               .clr   (clr),
               .ld    (ld & addr_hit[i]),
               .d     (in),
               .q     (regs[i])
            );
         end
      end
   endgenerate

   // Forwarding is legal only for a real write to a writable register;
   // gated by rst_n so the ports read zero throughout reset.
   assign bypass_ok = (BYPASS != 0) && rst_n && ld && !clr && (|addr_hit);

   // Read port A: compare-based mux so out-of-range addresses read zero
   always_comb begin
      out_a = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (rd_addr_a == AW'(k)) begin
            out_a = regs[k];
         end
      end
      if (bypass_ok && (rd_addr_a == wr_addr)) begin
         out_a = in;
      end
   end

   // Read port B: identical structure to port A
   always_comb begin
      out_b = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (rd_addr_b == AW'(k)) begin
            out_b = regs[k];
         end
      end
      if (bypass_ok && (rd_addr_b == wr_addr)) begin
         out_b = in;
      end
   end

endmodule : reg_bank
`default_nettype wire
